// File: rtl/joy_db9_condition.sv
// DB9 joystick conditioning: synchronizes, debounces, resolves SOCD and adds
// autofire on the C button for two 12-bit joystick ports.
module joy_db9_condition #(
    parameter int TICK_DIV = 1024,
    parameter int DB_TICKS = 4,
    parameter int AF_HALF  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] joy1_in,
    input  logic [11:0] joy2_in,
    input  logic [1:0]  af_en,
    output logic [11:0] joy1_out,
    output logic [11:0] joy2_out,
    output logic [1:0]  joy_chg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int AW = (AF_HALF  > 1) ? $clog2(AF_HALF)  : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_TICKS - 1);
    localparam logic [AW-1:0] AF_LAST    = AW'(AF_HALF - 1);

    localparam int BIT_R = 0;
    localparam int BIT_L = 1;
    localparam int BIT_D = 2;
    localparam int BIT_U = 3;
    localparam int BIT_C = 4;
    localparam int BIT_X = 7;

    // Both ports are handled as one 24-bit vector: port 1 in [11:0], port 2 in [23:12].
    logic [23:0]         sync_meta_r;
    logic [23:0]         sync_r;
    logic [23:0]         stable_r;
    logic [23:0][DW-1:0] db_cnt_r;
    logic [PW-1:0]       presc_r;
    logic                tick_s;
    logic [AW-1:0]       af_cnt_r;
    logic                phase_r;
    logic [11:0]         joy1_out_r;
    logic [11:0]         joy2_out_r;
    logic [11:0]         joy1_prev_r;
    logic [11:0]         joy2_prev_r;
    logic [1:0]          joy_chg_r;
    logic [11:0]         joy1_next_s;
    logic [11:0]         joy2_next_s;

    // Opposing directions cancel; C optionally gets the autofire-gated X.
    function automatic logic [11:0] condition_word(
        input logic [11:0] stable,
        input logic        af,
        input logic        phase
    );
        logic [11:0] w;
        w = stable;
        if (stable[BIT_U] && stable[BIT_D]) begin
            w[BIT_U] = 1'b0;
            w[BIT_D] = 1'b0;
        end else begin
            w[BIT_U] = stable[BIT_U];
            w[BIT_D] = stable[BIT_D];
        end
        if (stable[BIT_L] && stable[BIT_R]) begin
            w[BIT_L] = 1'b0;
            w[BIT_R] = 1'b0;
        end else begin
            w[BIT_L] = stable[BIT_L];
            w[BIT_R] = stable[BIT_R];
        end
        if (af) begin
            w[BIT_C] = stable[BIT_C] | (stable[BIT_X] & phase);
        end else begin
            w[BIT_C] = stable[BIT_C];
        end
        return w;
    endfunction

    // Two-flop synchronizer for all 24 asynchronous input bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_r <= 24'h000000;
            sync_r      <= 24'h000000;
        end else begin
            sync_meta_r <= {joy2_in, joy1_in};
            sync_r      <= sync_meta_r;
        end
    end

    // Sample-tick prescaler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= {PW{1'b0}};
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    // Per-bit debounce: a change commits after DB_TICKS consecutive disagreeing ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_r <= 24'h000000;
            db_cnt_r <= '0;
        end else if (tick_s) begin
            for (int i = 0; i < 24; i++) begin
                if (sync_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= {DW{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    stable_r[i] <= sync_r[i];
                    db_cnt_r[i] <= {DW{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
                end
            end
        end else begin
            stable_r <= stable_r;
            db_cnt_r <= db_cnt_r;
        end
    end

    // Shared autofire phase, toggling every AF_HALF ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_r <= {AW{1'b0}};
            phase_r  <= 1'b0;
        end else if (tick_s) begin
            if (af_cnt_r == AF_LAST) begin
                af_cnt_r <= {AW{1'b0}};
                phase_r  <= ~phase_r;
            end else begin
                af_cnt_r <= af_cnt_r + AW'(1);
                phase_r  <= phase_r;
            end
        end else begin
            af_cnt_r <= af_cnt_r;
            phase_r  <= phase_r;
        end
    end

    // Next output words from the debounced state.
    always_comb begin
        joy1_next_s = condition_word(stable_r[11:0],  af_en[0], phase_r);
        joy2_next_s = condition_word(stable_r[23:12], af_en[1], phase_r);
    end

    // Output registers; the change pulse follows one cycle after a new word appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy1_out_r  <= 12'h000;
            joy2_out_r  <= 12'h000;
            joy1_prev_r <= 12'h000;
            joy2_prev_r <= 12'h000;
            joy_chg_r   <= 2'b00;
        end else begin
            joy1_out_r  <= joy1_next_s;
            joy2_out_r  <= joy2_next_s;
            joy1_prev_r <= joy1_out_r;
            joy2_prev_r <= joy2_out_r;
            joy_chg_r   <= {(joy2_out_r != joy2_prev_r), (joy1_out_r != joy1_prev_r)};
        end
    end

    assign joy1_out = joy1_out_r;
    assign joy2_out = joy2_out_r;
    assign joy_chg  = joy_chg_r;

endmodule
